fp_dispatcher: RTL and testbench

Downstream stage of the fixed-priority arbiter: consumes the arbiter's `valid`/`selection` pair, pops one packet from the granted per-queue FIFO, and presents it on a single valid/ready output channel toward the memory port. It sequences pops so each arbitration decision is taken only after the arbiter's registered priority view has absorbed the previous pop. One packet is in flight at a time.

---
 rtl/fp_dispatcher.sv | 107 ++++++++++
 tb/tb_fp_dispatcher.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_dispatcher.sv
// Fixed-priority dispatcher: pops the arbiter-granted FIFO and presents one packet at a time on a valid/ready port.
// Optional per-queue grant counters are enabled by defining FP_DISPATCHER_STATS_EN.
module fp_dispatcher #(
    parameter  int NUMBER_OF_QUEUES = 4,
    parameter  int DATA_WIDTH       = 64,
    parameter  int COUNTER_WIDTH    = 32,
    localparam int SEL_W            = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   sel_valid,
    input  logic [SEL_W-1:0]                       selection,
    input  logic [NUMBER_OF_QUEUES-1:0]            empty,
    input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0] queue_data,
    output logic [NUMBER_OF_QUEUES-1:0]            pop,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic [SEL_W-1:0]                       m_source
`ifdef FP_DISPATCHER_STATS_EN
    ,
    output logic [NUMBER_OF_QUEUES*COUNTER_WIDTH-1:0] grant_count
`endif
);

    typedef enum logic [1:0] {IDLE, SEND, SETTLE} state_t;

    localparam logic [SEL_W:0] NQ_L = (SEL_W+1)'(NUMBER_OF_QUEUES);

    state_t                  state_q, state_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic [SEL_W-1:0]        m_source_q, m_source_d;
    logic                    sel_ok;
    logic                    fire;

    if (NUMBER_OF_QUEUES < 2 || COUNTER_WIDTH < 1) begin : g_bad_params
        $error("fp_dispatcher: NUMBER_OF_QUEUES must be >= 2 and COUNTER_WIDTH >= 1");
    end

    // A stale arbiter view (empty queue) or an out-of-range id is simply not a request.
    assign sel_ok = ({1'b0, selection} < NQ_L);
    assign fire   = !reset && (state_q == IDLE) && sel_valid && sel_ok && !empty[selection];

    always_comb begin
        state_d    = state_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_source_d = m_source_q;
        pop        = '0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    pop[selection] = 1'b1;
                    m_data_d       = queue_data[selection*DATA_WIDTH +: DATA_WIDTH];
                    m_source_d     = selection;
                    m_valid_d      = 1'b1;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = SETTLE;
                end
            end
            // One dead cycle lets the arbiter register the FIFO's updated empty flag.
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_source_q <= '0;
        end else begin
            state_q    <= state_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_source_q <= m_source_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_source = m_source_q;

`ifdef FP_DISPATCHER_STATS_EN
    for (genvar i = 0; i < NUMBER_OF_QUEUES; i++) begin : g_cnt
        logic [COUNTER_WIDTH-1:0] cnt_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (pop[i]) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign grant_count[i*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_fp_dispatcher.sv
// Directed bench for fp_dispatcher: reset, throughput, backpressure, stale-empty, mid-flight reset
// and (with FP_DISPATCHER_STATS_EN) grant counters including wrap.
module tb_fp_dispatcher;

    localparam int NQ = 4;
    localparam int DW = 64;
`ifdef FP_DISPATCHER_STATS_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif
    localparam int SW = $clog2(NQ);

    logic              clock = 1'b0;
    logic              reset;
    logic              sel_valid;
    logic [SW-1:0]     selection;
    logic [NQ-1:0]     empty;
    logic [NQ*DW-1:0]  queue_data;
    logic [NQ-1:0]     pop;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [SW-1:0]     m_source;
`ifdef FP_DISPATCHER_STATS_EN
    logic [NQ*CW-1:0]  grant_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fp_dispatcher #(
        .NUMBER_OF_QUEUES(NQ),
        .DATA_WIDTH      (DW),
        .COUNTER_WIDTH   (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sel_valid (sel_valid),
        .selection (selection),
        .empty     (empty),
        .queue_data(queue_data),
        .pop       (pop),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_source  (m_source)
`ifdef FP_DISPATCHER_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_q(input int q, input logic [DW-1:0] v);
        queue_data[q*DW +: DW] = v;
    endtask

`ifdef FP_DISPATCHER_STATS_EN
    // One full transaction with ready high: pop, send, settle, back in IDLE.
    task automatic grant(input int q);
        logic [NQ-1:0] exp_pop;
        exp_pop        = '0;
        exp_pop[q]     = 1'b1;
        sel_valid      = 1'b1;
        selection      = SW'(q);
        empty          = '0;
        m_ready        = 1'b1;
        @(negedge clock);
        check("grant_pop", 64'(pop), 64'(exp_pop));
        cyc();
        sel_valid = 1'b0;
        cyc();
        cyc();
    endtask
`endif

    initial begin
        reset      = 1'b1;
        sel_valid  = 1'b1;
        selection  = 2'd2;
        empty      = '0;
        m_ready    = 1'b1;
        queue_data = '0;
        set_q(0, 64'h11);
        set_q(1, 64'h22);
        set_q(2, 64'hA5);
        set_q(3, 64'h1234);
        cyc();

        // Reset held with every queue non-empty
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_pop",    64'(pop),      64'h0);
            check("rst_mvalid", 64'(m_valid),  64'h0);
            check("rst_mdata",  m_data,        64'h0);
            check("rst_msrc",   64'(m_source), 64'h0);
            cyc();
        end
        reset = 1'b0;

        // Peak throughput: pop at t, valid at t+1, settle at t+2, pop at t+3
        @(negedge clock);
        check("t0_pop", 64'(pop), 64'h4);
        cyc();
        @(negedge clock);
        check("t1_mvalid", 64'(m_valid),  64'h1);
        check("t1_mdata",  m_data,        64'hA5);
        check("t1_msrc",   64'(m_source), 64'h2);
        check("t1_pop",    64'(pop),      64'h0);
        cyc();
        @(negedge clock);
        check("t2_mvalid", 64'(m_valid), 64'h0);
        check("t2_pop",    64'(pop),     64'h0);
        cyc();
        @(negedge clock);
        check("t3_pop", 64'(pop), 64'h4);
        cyc();

        // Backpressure for 10 cycles; head of queue 2 changes underneath
        m_ready = 1'b0;
        set_q(2, 64'hFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_mvalid", 64'(m_valid),  64'h1);
            check("bp_mdata",  m_data,        64'hA5);
            check("bp_msrc",   64'(m_source), 64'h2);
            check("bp_pop",    64'(pop),      64'h0);
            cyc();
        end
        m_ready = 1'b1;
        @(negedge clock);
        check("rel_mvalid", 64'(m_valid), 64'h1);
        cyc();

        // Settle cycle; meanwhile arbiter offers a queue it believes non-empty but is empty
        selection = 2'd1;
        empty     = 4'b0010;
        @(negedge clock);
        check("settle_mvalid", 64'(m_valid), 64'h0);
        check("settle_pop",    64'(pop),     64'h0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stale_pop",    64'(pop),     64'h0);
            check("stale_mvalid", 64'(m_valid), 64'h0);
            cyc();
        end

        // Reset while a packet is in SEND
        empty     = '0;
        selection = 2'd3;
        @(negedge clock);
        check("rs_pop", 64'(pop), 64'h8);
        cyc();
        m_ready = 1'b0;
        @(negedge clock);
        check("rs_mvalid", 64'(m_valid),  64'h1);
        check("rs_mdata",  m_data,        64'h1234);
        check("rs_msrc",   64'(m_source), 64'h3);
        reset = 1'b1;
        cyc();
        @(negedge clock);
        check("rs_after_mvalid", 64'(m_valid), 64'h0);
        check("rs_after_mdata",  m_data,       64'h0);
        check("rs_after_pop",    64'(pop),     64'h0);
        reset     = 1'b0;
        sel_valid = 1'b0;
        m_ready   = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("rs_idle_pop",    64'(pop),     64'h0);
            check("rs_idle_mvalid", 64'(m_valid), 64'h0);
            cyc();
        end

`ifdef FP_DISPATCHER_STATS_EN
        check("cnt_rst_q0", 64'(grant_count[0*CW +: CW]), 64'h0);
        for (int i = 0; i < 5; i++) grant(0);
        for (int i = 0; i < 3; i++) grant(3);
        check("cnt_q0", 64'(grant_count[0*CW +: CW]), 64'd5);
        check("cnt_q1", 64'(grant_count[1*CW +: CW]), 64'd0);
        check("cnt_q2", 64'(grant_count[2*CW +: CW]), 64'd0);
        check("cnt_q3", 64'(grant_count[3*CW +: CW]), 64'd3);
        for (int i = 0; i < 16; i++) grant(1);
        check("cnt_wrap_q1", 64'(grant_count[1*CW +: CW]), 64'd0);
        check("cnt_wrap_q0", 64'(grant_count[0*CW +: CW]), 64'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
